// File: rtl/host_irq_pkg.sv
// Shared constants for the host interrupt collector: register map, widths and a
// helper that zero-extends a per-source vector onto the 16-bit bus.
package host_irq_pkg;

    localparam int REG_W          = 16;
    localparam int STATUS_IRQ_BIT = 15;
    localparam int MAX_IRQ        = 16;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_RAW     = 3'd2;
    localparam logic [2:0] ADDR_MODE    = 3'd3;
    localparam logic [2:0] ADDR_OVERRUN = 3'd4;
    localparam logic [2:0] ADDR_COUNT   = 3'd5;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;

    // Callers pass a MAX_IRQ-wide vector already zero-padded above NUM_IRQ.
    function automatic logic [REG_W-1:0] to_bus(input logic [MAX_IRQ-1:0] v);
        return REG_W'(v);
    endfunction

endpackage

// File: rtl/host_irq_edge_det.sv
// One-bit sampler plus rising-edge detector. HOST_IRQ_COLLECTOR_SYNC_EN adds a
// two-flop synchronizer ahead of the edge detector for asynchronous sources.
module host_irq_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic raw_o,
    output logic rise_o
);

`ifdef HOST_IRQ_COLLECTOR_SYNC_EN
    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: async active-low reset in the sensitivity list; state updates use <= only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign raw_o   = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;
`else
    logic sample_q;

    // NOTE: async active-low reset in the sensitivity list; state updates use <= only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= d_i;
        end
    end

    // Same-domain source: compare the live input against last cycle's sample so the
    // event lands in PENDING at the very edge that first sees the input high.
    assign level_o = d_i;
    assign raw_o   = sample_q;
    assign rise_o  = d_i & ~sample_q;
`endif

endmodule

// File: rtl/host_irq_collector.sv
// Avalon-MM interrupt collector: per-source pending/mask/mode/overrun registers,
// an accepted-event counter and a combined irq. Option: HOST_IRQ_COLLECTOR_SYNC_EN.
module host_irq_collector
    import host_irq_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [REG_W-1:0]   writedata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [REG_W-1:0]   readdata,
    output logic               irq
);

    logic [NUM_IRQ-1:0] level;
    logic [NUM_IRQ-1:0] raw;
    logic [NUM_IRQ-1:0] rise;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
        host_irq_edge_det u_edge_det (
            .clk     (clk),
            .reset_n (reset_n),
            .d_i     (irq_in[i]),
            .level_o (level[i]),
            .raw_o   (raw[i]),
            .rise_o  (rise[i])
        );
    end

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q,    mask_d;
    logic [NUM_IRQ-1:0] mode_q,    mode_d;
    logic [NUM_IRQ-1:0] overrun_q, overrun_d;
    logic [REG_W-1:0]   count_q,   count_d;
    logic [REG_W-1:0]   readdata_q, readdata_d;

    logic               wr_en;
    logic [NUM_IRQ-1:0] wr_bits;
    logic [NUM_IRQ-1:0] w1c_pend;
    logic [NUM_IRQ-1:0] w1c_ovr;
    logic [NUM_IRQ-1:0] edge_evt;
    logic               any_evt;
    logic               unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign wr_bits  = writedata[NUM_IRQ-1:0];
    // Upper data bits are deliberately ignored when NUM_IRQ < 16.
    assign unused_wdata = &{1'b0, writedata};

    assign irq = |(pending_q & mask_q);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w1c_pend  = '0;
        w1c_ovr   = '0;
        mask_d    = mask_q;
        mode_d    = mode_q;
        if (wr_en) begin
            case (address)
                ADDR_PENDING: w1c_pend = wr_bits;
                ADDR_MASK:    mask_d   = wr_bits;
                ADDR_MODE:    mode_d   = wr_bits;
                ADDR_OVERRUN: w1c_ovr  = wr_bits;
                default: ;
            endcase
        end

        // Only edge-mode sources produce counted events; level sources just mirror.
        edge_evt  = rise & mode_q;
        any_evt   = |edge_evt;
        pending_d = (mode_q & (edge_evt | (pending_q & ~w1c_pend))) | (~mode_q & level);
        overrun_d = (overrun_q & ~w1c_ovr) | (edge_evt & pending_q & ~w1c_pend);

        count_d = count_q;
        if (wr_en && address == ADDR_COUNT) begin
            count_d = any_evt ? REG_W'(1) : '0;
        end else if (any_evt) begin
            count_d = count_q + REG_W'(1);
        end

        readdata_d = '0;
        case (address)
            ADDR_PENDING: readdata_d = to_bus(MAX_IRQ'(pending_q));
            ADDR_MASK:    readdata_d = to_bus(MAX_IRQ'(mask_q));
            ADDR_RAW:     readdata_d = to_bus(MAX_IRQ'(raw));
            ADDR_MODE:    readdata_d = to_bus(MAX_IRQ'(mode_q));
            ADDR_OVERRUN: readdata_d = to_bus(MAX_IRQ'(overrun_q));
            ADDR_COUNT:   readdata_d = count_q;
            ADDR_STATUS: begin
                readdata_d = to_bus(MAX_IRQ'(pending_q & mask_q));
                readdata_d[STATUS_IRQ_BIT] = irq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            mask_q     <= '0;
            mode_q     <= '1;
            overrun_q  <= '0;
            count_q    <= '0;
            readdata_q <= '0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            overrun_q  <= overrun_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
